// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the mult/div issue controller.
//   md_op_t     : EX-stage mult/div opcode as decoded by ID
//   md_uop_t    : 2-bit operation code sent to the mult/div unit
//   md_state_t  : issue FSM states
//   MULT_LAT, DIV_LAT : expected busy latency of the unit, in cycles
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULTU = 4'd1,
        MD_MULT  = 4'd2,
        MD_DIVU  = 4'd3,
        MD_DIV   = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        UOP_MULTU = 2'b00,
        UOP_MULT  = 2'b01,
        UOP_DIVU  = 2'b10,
        UOP_DIV   = 2'b11
    } md_uop_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if -- command/status bus between the issue controller and
// the mult/div unit.
//   md_d1, md_d2 : operands (md_d1 also carries MTHI/MTLO write data)
//   md_op        : unit operation code (md_uop_t encoding)
//   md_start     : one-cycle start pulse for a multiply/divide
//   md_we        : one-cycle HI/LO write strobe, md_hilo selects HI (1) / LO (0)
//   md_busy      : unit is computing
//   md_hi, md_lo : unit result registers
// Modports: master = issue controller, slave = mult/div unit.
interface md_issue_ctrl_if;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic [1:0]  md_op;
    logic        md_start;
    logic        md_we;
    logic        md_hilo;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_d1, md_d2, md_op, md_start, md_we, md_hilo,
        input  md_busy, md_hi, md_lo
    );

    modport slave (
        input  md_d1, md_d2, md_op, md_start, md_we, md_hilo,
        output md_busy, md_hi, md_lo
    );
endinterface

// File: rtl/md_lat_chk.sv
// md_lat_chk -- cross-checks the unit's busy window against the expected
// latency and raises a sticky error on disagreement.
//   Clk, Rst_n  : clock, synchronous active-low reset
//   start       : operation issued this cycle
//   is_div      : the issued operation is a divide
//   in_wait     : issue FSM is in WAIT
//   first_wait  : first WAIT cycle (busy not yet visible)
//   busy        : unit busy
//   seq_err     : sticky latency-mismatch flag
module md_lat_chk
    import md_pkg::*;
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic start,
    input  logic is_div,
    input  logic in_wait,
    input  logic first_wait,
    input  logic busy,
    output logic seq_err
);

    logic [3:0] cnt;
    logic       mismatch;

    // busy must stay high exactly until the counter expires
    assign mismatch = in_wait && !first_wait &&
                      ((busy && (cnt == 4'd0)) || (!busy && (cnt != 4'd0)));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt     <= 4'd0;
            seq_err <= 1'b0;
        end else begin
            if (start)
                cnt <= is_div ? DIV_LAT : MULT_LAT;
            else if (in_wait && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (mismatch)
                seq_err <= 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl -- issues EX-stage mult/div/move instructions to the
// mult/div unit, stalls the pipe while the unit is busy and returns
// MFHI/MFLO data.
//   Clk, Rst_n        : clock, synchronous active-low reset
//   ex_valid          : EX instruction valid
//   ex_md_op          : EX mult/div opcode
//   rs_val, rt_val    : forwarded EX operands
//   int_flush         : EX instruction cancelled this cycle
//   md (master)       : command/status bus to the unit
//   stall             : freeze IF/ID/EX, bubble MEM
//   md_rdata          : MFHI/MFLO result
//   seq_err           : sticky latency-mismatch flag
// Build option: DIV_ZERO_GUARD_EN suppresses DIVU/DIV issue when rt_val==0.
module md_issue_ctrl
    import md_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ex_valid,
    input  md_op_t      ex_md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        int_flush,
    md_issue_ctrl_if.master md,
    output logic        stall,
    output logic [31:0] md_rdata,
    output logic        seq_err
);

    md_state_t state, state_nxt;
    logic      first_wait;
    logic      op_muldiv, op_div, op_mt;
    logic      stall_c, issue_ok, div_zero_blk;
    logic      start_c, we_c;
    md_uop_t   uop;

    assign op_div    = (ex_md_op == MD_DIVU) || (ex_md_op == MD_DIV);
    assign op_muldiv = (ex_md_op == MD_MULTU) || (ex_md_op == MD_MULT) || op_div;
    assign op_mt     = (ex_md_op == MD_MTHI) || (ex_md_op == MD_MTLO);

`ifdef DIV_ZERO_GUARD_EN
    assign div_zero_blk = op_div && (rt_val == 32'd0);
`else
    assign div_zero_blk = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            first_wait <= 1'b0;
        end else begin
            state      <= state_nxt;
            first_wait <= start_c;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_c   = ex_valid && (ex_md_op != MD_NONE) && (state == ST_WAIT) &&
                    (md.md_busy || first_wait);
        // Issue window: IDLE, or the WAIT cycle in which the unit has just
        // finished, so a stalled instruction issues as it is released.
        issue_ok  = Rst_n && ex_valid && !int_flush && !stall_c &&
                    ((state == ST_IDLE) ||
                     (state == ST_WAIT && !first_wait && !md.md_busy));
        start_c   = issue_ok && op_muldiv && !div_zero_blk;
        we_c      = issue_ok && op_mt;
        case (state)
            ST_IDLE: if (start_c) state_nxt = ST_WAIT;
            ST_WAIT: if (!first_wait && !md.md_busy)
                         state_nxt = start_c ? ST_WAIT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        uop = UOP_MULTU;
        case (ex_md_op)
            MD_MULT: uop = UOP_MULT;
            MD_DIVU: uop = UOP_DIVU;
            MD_DIV:  uop = UOP_DIV;
            default: uop = UOP_MULTU;
        endcase
    end

    always_comb begin
        md_rdata = 32'd0;
        if (!stall_c) begin
            if (ex_md_op == MD_MFHI)      md_rdata = md.md_hi;
            else if (ex_md_op == MD_MFLO) md_rdata = md.md_lo;
        end
    end

    assign md.md_d1    = rs_val;
    assign md.md_d2    = rt_val;
    assign md.md_op    = uop;
    assign md.md_start = start_c;
    assign md.md_we    = we_c;
    assign md.md_hilo  = (ex_md_op == MD_MTHI);
    assign stall       = Rst_n && stall_c;

    md_lat_chk u_lat_chk (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .start      (start_c),
        .is_div     (op_div),
        .in_wait    (state == ST_WAIT),
        .first_wait (first_wait),
        .busy       (md.md_busy),
        .seq_err    (seq_err)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl -- directed bench for md_issue_ctrl with a behavioural
// mult/div unit: busy rises one cycle after start and falls after the
// nominal latency, results land in HI/LO as busy falls.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ex_valid;
    md_op_t      ex_md_op;
    logic [31:0] rs_val, rt_val;
    logic        int_flush;
    logic        stall;
    logic [31:0] md_rdata;
    logic        seq_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    md_issue_ctrl_if bus ();

    md_issue_ctrl dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .ex_valid  (ex_valid),
        .ex_md_op  (ex_md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .int_flush (int_flush),
        .md        (bus),
        .stall     (stall),
        .md_rdata  (md_rdata),
        .seq_err   (seq_err)
    );

    // ---------------- behavioural mult/div unit ----------------
    logic [3:0]  u_cnt, u_lat;
    logic [31:0] u_hi, u_lo, p_hi, p_lo;
    logic        force_drop;

    assign bus.md_busy = (u_cnt != 4'd0) && (u_cnt != u_lat) && !force_drop;
    assign bus.md_hi   = u_hi;
    assign bus.md_lo   = u_lo;

    function automatic logic [63:0] unit_calc(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] pa, pb;
        logic signed [31:0] sa, sb, q, rm;
        logic [63:0] r;
        sa = a; sb = b; pa = sa; pb = sb;
        case (op)
            2'b00:   r = {32'd0, a} * {32'd0, b};
            2'b01:   r = pa * pb;
            2'b10:   r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin q = sa / sb; rm = sa % sb; r = {rm, q}; end
            end
        endcase
        return r;
    endfunction

    always @(posedge Clk) begin
        if (!Rst_n) begin
            u_cnt <= 4'd0; u_lat <= 4'd0;
            u_hi  <= 32'd0; u_lo <= 32'd0;
            p_hi  <= 32'd0; p_lo <= 32'd0;
        end else begin
            if (bus.md_start) begin
                u_cnt <= bus.md_op[1] ? 4'd10 : 4'd5;
                u_lat <= bus.md_op[1] ? 4'd10 : 4'd5;
                {p_hi, p_lo} <= unit_calc(bus.md_op, bus.md_d1, bus.md_d2);
            end else if (u_cnt != 4'd0) begin
                u_cnt <= u_cnt - 4'd1;
                if (u_cnt == 4'd1) begin
                    u_hi <= p_hi;
                    u_lo <= p_lo;
                end
            end
            if (bus.md_we) begin
                if (bus.md_hilo) u_hi <= bus.md_d1;
                else             u_lo <= bus.md_d1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input md_op_t op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl);
        @(posedge Clk);
        #1;
        ex_valid = v; ex_md_op = op; rs_val = rs; rt_val = rt; int_flush = fl;
        @(negedge Clk);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Expects n stalled cycles starting now, then checks the release cycle.
    task automatic stall_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) tick();
            chk({tag, "_stall"},   32'(stall), 32'd1);
            chk({tag, "_nostart"}, 32'(bus.md_start), 32'd0);
            chk({tag, "_rd0"},     md_rdata, 32'd0);
        end
        tick();
        chk({tag, "_release"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; ex_valid = 1'b1; ex_md_op = MD_MULT;
        rs_val = 32'd5; rt_val = 32'd6; int_flush = 1'b0; force_drop = 1'b0;

        // reset: outputs quiet even with a MULT presented
        @(posedge Clk); @(negedge Clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_start", 32'(bus.md_start), 32'd0);
        chk("rst_we",    32'(bus.md_we), 32'd0);
        tick();
        chk("rst_seqerr", 32'(seq_err), 32'd0);

        // MULT -1 * 2, then MFLO / MFHI
        @(posedge Clk); #1;
        Rst_n = 1'b1; ex_valid = 1'b1; ex_md_op = MD_MULT;
        rs_val = 32'hFFFFFFFF; rt_val = 32'd2;
        @(negedge Clk);
        chk("mult_start", 32'(bus.md_start), 32'd1);
        chk("mult_op",    32'(bus.md_op), 32'd1);
        chk("mult_d1",    bus.md_d1, 32'hFFFFFFFF);
        chk("mult_d2",    bus.md_d2, 32'd2);
        chk("mult_stall", 32'(stall), 32'd0);
        chk("mult_we",    32'(bus.md_we), 32'd0);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        stall_run("mult_mflo", 5);
        chk("mult_lo", md_rdata, 32'hFFFFFFFE);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mult_hi",       md_rdata, 32'hFFFFFFFF);
        chk("mult_hi_stall", 32'(stall), 32'd0);
        chk("mult_seqerr",   32'(seq_err), 32'd0);

        // DIVU 100 / 7, MFHI back-to-back
        step(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        chk("divu_start", 32'(bus.md_start), 32'd1);
        chk("divu_op",    32'(bus.md_op), 32'd2);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        stall_run("divu_mfhi", 10);
        chk("divu_hi", md_rdata, 32'd2);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("divu_lo", md_rdata, 32'd14);

        // MTLO / MTHI
        step(1'b1, MD_MTLO, 32'h1234, 32'd0, 1'b0);
        chk("mtlo_we",    32'(bus.md_we), 32'd1);
        chk("mtlo_hilo",  32'(bus.md_hilo), 32'd0);
        chk("mtlo_start", 32'(bus.md_start), 32'd0);
        chk("mtlo_d1",    bus.md_d1, 32'h1234);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("mtlo_rd_stall", 32'(stall), 32'd0);
        chk("mtlo_rd",       md_rdata, 32'h1234);
        step(1'b1, MD_MTHI, 32'hABCD, 32'd0, 1'b0);
        chk("mthi_we",   32'(bus.md_we), 32'd1);
        chk("mthi_hilo", 32'(bus.md_hilo), 32'd1);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("mthi_rd", md_rdata, 32'hABCD);

        // flushed MULT does not issue; FSM stays idle
        step(1'b1, MD_MULT, 32'd3, 32'd4, 1'b1);
        chk("flush_start", 32'(bus.md_start), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        chk("flush_idle_lo",    md_rdata, 32'h1234);

        // signed DIV -20 / 3 with a flush during WAIT
        step(1'b1, MD_DIV, 32'hFFFFFFEC, 32'd3, 1'b0);
        chk("div_start", 32'(bus.md_start), 32'd1);
        chk("div_op",    32'(bus.md_op), 32'd3);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b1);
        chk("div_flush_stall", 32'(stall), 32'd1);
        chk("div_flush_start", 32'(bus.md_start), 32'd0);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        chk("div_bubble_stall", 32'(stall), 32'd0);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        stall_run("div_mflo", 8);
        chk("div_lo", md_rdata, 32'hFFFFFFFA);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("div_hi", md_rdata, 32'hFFFFFFFE);
        chk("div_seqerr", 32'(seq_err), 32'd0);

        // MULT arriving during DIVU WAIT issues as the stall releases
        step(1'b1, MD_DIVU, 32'd50, 32'd5, 1'b0);
        chk("b2b_div_start", 32'(bus.md_start), 32'd1);
        step(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0);
        stall_run("b2b_mult", 10);
        chk("b2b_mult_start", 32'(bus.md_start), 32'd1);
        chk("b2b_mult_op",    32'(bus.md_op), 32'd1);
        chk("b2b_mult_d1",    bus.md_d1, 32'd3);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        stall_run("b2b_mflo", 5);
        chk("b2b_lo", md_rdata, 32'd12);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        chk("b2b_hi", md_rdata, 32'd0);
        chk("b2b_seqerr", 32'(seq_err), 32'd0);

        // divide by zero
        step(1'b1, MD_DIV, 32'd77, 32'd0, 1'b0);
`ifdef DIV_ZERO_GUARD_EN
        chk("dz_start", 32'(bus.md_start), 32'd0);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("dz_stall", 32'(stall), 32'd0);
        chk("dz_lo",    md_rdata, 32'd12);
`else
        chk("dz_start", 32'(bus.md_start), 32'd1);
        step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
        stall_run("dz_mfhi", 10);
        chk("dz_hi", md_rdata, 32'd77);
`endif

        // reset in the middle of WAIT
        step(1'b1, MD_MULT, 32'd2, 32'd2, 1'b0);
        chk("rw_start", 32'(bus.md_start), 32'd1);
        @(posedge Clk); #1;
        Rst_n = 1'b0; ex_md_op = MD_MFLO;
        @(negedge Clk);
        chk("rw_rst_stall", 32'(stall), 32'd0);
        chk("rw_rst_start", 32'(bus.md_start), 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rw_idle_stall", 32'(stall), 32'd0);
        chk("rw_seqerr",     32'(seq_err), 32'd0);

        // early busy drop -> sticky seq_err
        step(1'b1, MD_MULT, 32'd1, 32'd1, 1'b0);
        chk("ed_start", 32'(bus.md_start), 32'd1);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        chk("ed_first_stall", 32'(stall), 32'd1);
        @(posedge Clk); #1;
        force_drop = 1'b1;
        @(negedge Clk);
        chk("ed_drop_stall",  32'(stall), 32'd0);
        chk("ed_drop_seqerr", 32'(seq_err), 32'd0);
        @(posedge Clk); #1;
        force_drop = 1'b0;
        @(negedge Clk);
        chk("ed_seqerr_set", 32'(seq_err), 32'd1);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("ed_seqerr_sticky", 32'(seq_err), 32'd1);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("ed_seqerr_clr", 32'(seq_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have ports: Clk in 1, rising-edge clock; Rst_n in 1, synchronous active-low reset.
REQ-002 SHALL have ex_valid in 1: EX-stage instruction valid, not bubble.
REQ-003 SHALL have ex_md_op in 4: md_op_t code NONE, MULTU, MULT, DIVU, DIV, MTHI, MTLO, MFHI, MFLO.
REQ-004 SHALL have rs_val in 32 and rt_val in 32: forwarded EX operands.
REQ-005 SHALL have int_flush in 1: EX instruction is cancelled this cycle by interrupt/exception.
REQ-006 SHALL have md_busy in 1, md_hi in 32, md_lo in 32: status and results from the mult/div unit.
REQ-007 SHALL have md_d1 out 32, md_d2 out 32, md_op out 2, md_start out 1, md_we out 1, md_hilo out 1: command to the unit.
REQ-008 SHALL have stall out 1: freeze IF/ID/EX, bubble MEM.
REQ-009 SHALL have md_rdata out 32: MFHI/MFLO result into the EX result mux.
REQ-010 SHALL have seq_err out 1: sticky latency-mismatch flag.

Function
REQ-011 SHALL run an FSM with states IDLE and WAIT.
REQ-012 In IDLE, a valid, unflushed MULTU/MULT/DIVU/DIV SHALL assert md_start for exactly one cycle and move to WAIT.
REQ-013 md_op SHALL encode MULTU=00, MULT=01, DIVU=10, DIV=11.
REQ-014 md_d1 SHALL equal rs_val and md_d2 SHALL equal rt_val.
REQ-015 In IDLE, a valid, unflushed MTHI/MTLO SHALL assert md_we for one cycle, with md_hilo=1 for HI and 0 for LO, and md_d1=rs_val.
REQ-016 stall SHALL be combinational and equal ex_valid & (ex_md_op != NONE) & (state==WAIT) & (md_busy | first_wait_cycle).
REQ-017 first_wait_cycle SHALL be asserted in the WAIT cycle immediately after start, covering the edge before the unit raises busy.
REQ-018 WAIT SHALL return to IDLE on the first cycle with md_busy==0 after first_wait_cycle.
REQ-019 An instruction released from stall in that same cycle SHALL be issued per REQ-012/015.
REQ-020 md_start and md_we SHALL never be asserted while stall=1, while int_flush=1, or in the same cycle as each other.
REQ-021 MFHI/MFLO SHALL drive md_rdata=md_hi/md_lo combinationally when not stalled; otherwise md_rdata=0.
REQ-022 An internal 4-bit latency counter SHALL load 5 on a mult start and 10 on a div start, then decrement each WAIT cycle.
REQ-023 If md_busy deasserts while the counter is nonzero, or the counter reaches 0 with md_busy=1, seq_err SHALL set and hold until reset.
REQ-024 int_flush during WAIT SHALL NOT abort the in-flight operation; the FSM continues to IDLE normally.

Reset
REQ-025 On Clk edge with Rst_n=0, SHALL set state=IDLE, counter=0, first_wait_cycle=0, seq_err=0.
REQ-026 During reset, md_start, md_we, and stall SHALL be 0.
REQ-027 Reset during WAIT SHALL abandon tracking; the unit's own reset is driven separately.

Configuration
REQ-028 With DIV_ZERO_GUARD_EN defined, DIVU/DIV with rt_val==0 SHALL suppress md_start, stay IDLE, and leave HI/LO unchanged.
REQ-029 Without DIV_ZERO_GUARD_EN, division by zero SHALL issue normally.

Structure
REQ-030 md_op_t encodings and latency constants (MULT_LAT=5, DIV_LAT=10) SHALL reside in shared package md_pkg.
REQ-031 The latency checker (REQ-022/023) SHALL be sub-module md_lat_chk; the rest SHALL be flat.

Verification
REQ-032 MULT rs=0xFFFFFFFF, rt=2 -> md_start one cycle, md_op=01; following MFLO stalls until busy falls; md_rdata=0xFFFFFFFE, then MFHI=0xFFFFFFFF; seq_err=0.
REQ-033 DIVU rs=100, rt=7, then MFHI back-to-back -> stall for 10 cycles; MFHI returns 2, MFLO returns 14.
REQ-034 MTLO rs=0x1234 while IDLE -> md_we=1, md_hilo=0 one cycle; next MFLO returns 0x1234 with no stall.
REQ-035 MULT with int_flush=1 -> no md_start, state stays IDLE; a second MULT during WAIT of an earlier DIV stalls and issues after busy falls.
REQ-036 DIV rt=0 with DIV_ZERO_GUARD_EN -> no start, HI/LO unchanged; without the macro -> start issued.
REQ-037 Rst_n=0 mid-WAIT -> next cycle IDLE, stall=0, seq_err=0; forced early md_busy drop -> seq_err=1 sticky.
